// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM main controller.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
  } state_t;

  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_CS = 4'h2;
  localparam logic [3:0] CC_CC = 4'h3;
  localparam logic [3:0] CC_MI = 4'h4;
  localparam logic [3:0] CC_PL = 4'h5;
  localparam logic [3:0] CC_VS = 4'h6;
  localparam logic [3:0] CC_VC = 4'h7;
  localparam logic [3:0] CC_HI = 4'h8;
  localparam logic [3:0] CC_LS = 4'h9;
  localparam logic [3:0] CC_GE = 4'hA;
  localparam logic [3:0] CC_LT = 4'hB;
  localparam logic [3:0] CC_GT = 4'hC;
  localparam logic [3:0] CC_LE = 4'hD;
  localparam logic [3:0] CC_AL = 4'hE;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0010;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  // Flag register bit positions, packed as {N,Z,C,V}.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // TST/TEQ/CMP/CMN only update flags, never the register file.
  function automatic logic is_test_cmd(input logic [3:0] cmd);
    return cmd[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_cond_check.sv
// ARM condition-code evaluation against the {N,Z,C,V} flag register.
module cond_check
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);
  logic n, z, c, v;
  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond)
      CC_EQ:   pass = z;
      CC_NE:   pass = ~z;
      CC_CS:   pass = c;
      CC_CC:   pass = ~c;
      CC_MI:   pass = n;
      CC_PL:   pass = ~n;
      CC_VS:   pass = v;
      CC_VC:   pass = ~v;
      CC_HI:   pass = c & ~z;
      CC_LS:   pass = ~c | z;
      CC_GE:   pass = (n == v);
      CC_LT:   pass = (n != v);
      CC_GT:   pass = ~z & (n == v);
      CC_LE:   pass = z | (n != v);
      CC_AL:   pass = 1'b1;
      default: pass = 1'b0;  // 1111 never executes
    endcase
  end
endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle ARM main controller: fetch/decode/execute/memory/writeback sequencing.
// Optional: define CTRL_BL_LINK_EN so BL writes the return address to R14.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  input  logic        mem_ready,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [1:0]  RegSrc,
  output logic        RegWrite,
  output logic [1:0]  ImmSrc,
  output logic        ALUSrc,
  output logic [3:0]  ALUControl,
  output logic        MemtoReg,
  output logic        PCSrc,
  output logic        linkSelect,
  output logic [2:0]  shiftOp,
  output logic        storedCarry,
  output logic        undef,
  output logic        mem_err
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  state_t        state, nstate;
  logic [3:0]    flags;
  logic [CW-1:0] wait_cnt;
  logic          pass;
  logic          mem_state;
  logic          timeout;
  logic [3:0]    cmd;
  logic          unused_instr;

  assign cmd          = Instr[24:21];
  assign mem_state    = state inside {FETCH, MEMRD, MEMWR};
  assign timeout      = mem_state && (wait_cnt == CW'(MEM_TIMEOUT));
  assign unused_instr = ^{Instr[19:7], Instr[3:0]};

  cond_check u_cond (
    .cond  (Instr[31:28]),
    .flags (flags),
    .pass  (pass)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      flags    <= '0;
      wait_cnt <= '0;
    end else begin
      state <= nstate;
      // A timeout in FETCH re-enters FETCH, so it must clear the count too.
      if (timeout || nstate != state)
        wait_cnt <= '0;
      else if (mem_state)
        wait_cnt <= wait_cnt + CW'(1);
      if (state == ALUWB && Instr[20])
        flags <= ALUFlags;
    end
  end

  always_comb begin
    nstate      = state;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    AdrSrc      = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    RegSrc      = 2'b00;
    RegWrite    = 1'b0;
    ImmSrc      = IMM_DP;
    ALUSrc      = 1'b0;
    ALUControl  = 4'b0000;
    MemtoReg    = 1'b0;
    PCSrc       = 1'b0;
    linkSelect  = 1'b0;
    undef       = 1'b0;
    mem_err     = 1'b0;
    shiftOp     = {Instr[4], Instr[6:5]};
    storedCarry = flags[FLAG_C];

    case (state)
      FETCH: begin
        if (timeout) begin
          mem_err = 1'b1;
          nstate  = FETCH;
        end else begin
          MemRead = 1'b1;
          if (mem_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            nstate  = DECODE;
          end
        end
      end
      DECODE: begin
        if (!pass) begin
          nstate = FETCH;
        end else begin
          case (Instr[27:26])
            OP_DP:   nstate = Instr[25] ? EXECI : EXECR;
            OP_MEM:  nstate = MEMADR;
            OP_BR:   nstate = BRANCH;
            default: begin
              undef  = 1'b1;
              nstate = FETCH;
            end
          endcase
        end
      end
      EXECR, EXECI: begin
        ALUSrc     = Instr[25];
        ImmSrc     = IMM_DP;
        ALUControl = cmd;
        nstate     = ALUWB;
      end
      ALUWB: begin
        // Keep the ALU on the same operation so ALUFlags match the result written.
        ALUSrc     = Instr[25];
        ImmSrc     = IMM_DP;
        ALUControl = cmd;
        RegWrite   = ~is_test_cmd(cmd);
        nstate     = FETCH;
      end
      MEMADR, MEMRD, MEMWR: begin
        // Address comes straight from the ALU, so hold it for the whole access.
        ALUSrc     = 1'b1;
        ImmSrc     = IMM_MEM;
        ALUControl = Instr[23] ? ALU_ADD : ALU_SUB;
        if (state == MEMADR) begin
          nstate = Instr[20] ? MEMRD : MEMWR;
        end else if (timeout) begin
          mem_err = 1'b1;
          nstate  = FETCH;
        end else if (state == MEMRD) begin
          AdrSrc  = 1'b1;
          MemRead = 1'b1;
          if (mem_ready) nstate = MEMWB;
        end else begin
          AdrSrc   = 1'b1;
          MemWrite = 1'b1;
          RegSrc   = 2'b10;
          if (mem_ready) nstate = FETCH;
        end
      end
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        nstate   = FETCH;
      end
      BRANCH: begin
        RegSrc     = 2'b01;
        ImmSrc     = IMM_BR;
        ALUSrc     = 1'b1;
        ALUControl = ALU_ADD;
        PCSrc      = 1'b1;
        PCWrite    = 1'b1;
`ifdef CTRL_BL_LINK_EN
        if (Instr[24]) begin
          RegWrite   = 1'b1;
          linkSelect = 1'b1;
        end
`endif
        nstate = FETCH;
      end
      default: nstate = FETCH;
    endcase

    if (reset) begin
      nstate      = FETCH;
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      AdrSrc      = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      RegSrc      = 2'b00;
      RegWrite    = 1'b0;
      ImmSrc      = 2'b00;
      ALUSrc      = 1'b0;
      ALUControl  = 4'b0000;
      MemtoReg    = 1'b0;
      PCSrc       = 1'b0;
      linkSelect  = 1'b0;
      undef       = 1'b0;
      mem_err     = 1'b0;
      shiftOp     = 3'b000;
      storedCarry = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: per-cycle expected control words queued, then replayed and compared.
module tb_mc_ctrl_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        mem_ready;
  logic        IRWrite, PCWrite, AdrSrc, MemRead, MemWrite, RegWrite;
  logic [1:0]  RegSrc, ImmSrc;
  logic        ALUSrc, MemtoReg, PCSrc, linkSelect, storedCarry, undef, mem_err;
  logic [3:0]  ALUControl;
  logic [2:0]  shiftOp;

  mc_ctrl_fsm #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .mem_ready(mem_ready),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegSrc(RegSrc), .RegWrite(RegWrite), .ImmSrc(ImmSrc),
    .ALUSrc(ALUSrc), .ALUControl(ALUControl), .MemtoReg(MemtoReg), .PCSrc(PCSrc),
    .linkSelect(linkSelect), .shiftOp(shiftOp), .storedCarry(storedCarry),
    .undef(undef), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       irw, pcw, adr, mrd, mwr;
    logic [1:0] rsrc;
    logic       rw;
    logic [1:0] imm;
    logic       asrc;
    logic [3:0] aluc;
    logic       m2r, pcs, lnk, und, merr, sc;
    logic [2:0] sop;
  } ctl_t;

  typedef struct {
    string       name;
    logic [31:0] ins;
    bit          rst;
    bit          rdy;
    logic [3:0]  af;
    ctl_t        val;
    ctl_t        mask;
  } exp_t;

  ctl_t obs;
  assign obs = {IRWrite, PCWrite, AdrSrc, MemRead, MemWrite, RegSrc, RegWrite, ImmSrc,
                ALUSrc, ALUControl, MemtoReg, PCSrc, linkSelect, undef, mem_err,
                storedCarry, shiftOp};

  exp_t       sbq[$];
  logic [3:0] mflags = 4'b0000;
  int         checks = 0;
  int         errors = 0;

  localparam logic [31:0] I_ADDS = 32'hE2921005;
  localparam logic [31:0] I_ADD  = 32'hE2821005;
  localparam logic [31:0] I_CMP  = 32'hE1510332;
  localparam logic [31:0] I_BNE  = 32'h1AFFFFFE;
  localparam logic [31:0] I_BEQ  = 32'h0AFFFFFE;
  localparam logic [31:0] I_BL   = 32'hEBFFFFFE;
  localparam logic [31:0] I_NV   = 32'hF2921005;
  localparam logic [31:0] I_UND  = 32'hEC000000;
  localparam logic [31:0] I_LDR  = 32'hE5910004;
  localparam logic [31:0] I_STR  = 32'hE5010004;

  // Expected control words per state, straight from the state table.
  function automatic ctl_t c_fetch(bit rdy);
    ctl_t c = '0; c.mrd = 1'b1; c.irw = rdy; c.pcw = rdy; return c;
  endfunction
  function automatic ctl_t c_zero();
    ctl_t c = '0; return c;
  endfunction
  function automatic ctl_t c_exec(bit i, logic [3:0] cmd);
    ctl_t c = '0; c.asrc = i; c.aluc = cmd; return c;
  endfunction
  function automatic ctl_t c_wb(bit rw);
    ctl_t c = '0; c.rw = rw; return c;
  endfunction
  function automatic ctl_t c_madr(bit u);
    ctl_t c = '0; c.asrc = 1'b1; c.imm = 2'b01; c.aluc = u ? 4'b0100 : 4'b0010; return c;
  endfunction
  function automatic ctl_t c_mrd();
    ctl_t c = '0; c.adr = 1'b1; c.mrd = 1'b1; return c;
  endfunction
  function automatic ctl_t c_mwb();
    ctl_t c = '0; c.m2r = 1'b1; c.rw = 1'b1; return c;
  endfunction
  function automatic ctl_t c_mwr();
    ctl_t c = '0; c.adr = 1'b1; c.mwr = 1'b1; c.rsrc = 2'b10; return c;
  endfunction
  function automatic ctl_t c_br(bit link);
    ctl_t c = '0;
    c.rsrc = 2'b01; c.imm = 2'b10; c.asrc = 1'b1; c.aluc = 4'b0100; c.pcs = 1'b1; c.pcw = 1'b1;
    c.rw = link; c.lnk = link;
    return c;
  endfunction
  function automatic ctl_t c_und();
    ctl_t c = '0; c.und = 1'b1; return c;
  endfunction
  function automatic ctl_t c_err();
    ctl_t c = '0; c.merr = 1'b1; return c;
  endfunction

  // Queue one cycle of stimulus plus its expected outputs; tracks the flag model.
  task automatic push(input string nm, input logic [31:0] ins, input bit rst, input bit rdy,
                      input logic [3:0] af, input bit wfl, input ctl_t v, input bit malu);
    exp_t e;
    e.name = nm; e.ins = ins; e.rst = rst; e.rdy = rdy; e.af = af;
    e.val  = rst ? '0 : v;
    if (!rst) begin
      e.val.sc  = mflags[1];
      e.val.sop = {ins[4], ins[6:5]};
    end
    e.mask = '1;
    if (malu) begin
      e.mask.asrc = 1'b0; e.mask.imm = 2'b00; e.mask.aluc = 4'b0000;
    end
    sbq.push_back(e);
    if (rst) mflags = 4'b0000;
    else if (wfl) mflags = af;
  endtask

  task automatic test_reset();
    exp_t e;
    push("reset_hold0", 32'hE2921075, 1, 1, 4'hF, 0, c_zero(), 0);
    push("reset_hold1", 32'hE2921075, 1, 1, 4'hF, 0, c_zero(), 0);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      @(negedge clk);
      reset = e.rst; Instr = e.ins; mem_ready = e.rdy; ALUFlags = e.af;
      #1;
      checks++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL %s: observed %h, expected %h (mask %h)", e.name, obs, e.val, e.mask);
      end
    end
  endtask

  task automatic test_adds();
    exp_t e;
    push("adds_fetch",  I_ADDS, 0, 1, 4'hF, 0, c_fetch(1), 0);
    push("adds_decode", I_ADDS, 0, 1, 4'hF, 0, c_zero(), 0);
    push("adds_execi",  I_ADDS, 0, 1, 4'hF, 0, c_exec(1, 4'b0100), 0);
    push("adds_aluwb",  I_ADDS, 0, 1, 4'b0110, 1, c_wb(1), 1);
    push("add_fetch",   I_ADD,  0, 1, 4'hF, 0, c_fetch(1), 0);
    push("add_decode",  I_ADD,  0, 1, 4'hF, 0, c_zero(), 0);
    push("add_execi",   I_ADD,  0, 1, 4'hF, 0, c_exec(1, 4'b0100), 0);
    push("add_aluwb_noS", I_ADD, 0, 1, 4'b1001, 0, c_wb(1), 1);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      @(negedge clk);
      reset = e.rst; Instr = e.ins; mem_ready = e.rdy; ALUFlags = e.af;
      #1;
      checks++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL %s: observed %h, expected %h (mask %h)", e.name, obs, e.val, e.mask);
      end
    end
  endtask

  task automatic test_cond_branch();
    exp_t e;
    push("cmp_fetch",   I_CMP, 0, 1, 4'hF, 0, c_fetch(1), 0);
    push("cmp_decode",  I_CMP, 0, 1, 4'hF, 0, c_zero(), 0);
    push("cmp_execr",   I_CMP, 0, 1, 4'hF, 0, c_exec(0, 4'b1010), 0);
    push("cmp_aluwb",   I_CMP, 0, 1, 4'b0110, 1, c_wb(0), 1);
    push("bne_fetch",   I_BNE, 0, 1, 4'hF, 0, c_fetch(1), 0);
    push("bne_decode",  I_BNE, 0, 1, 4'hF, 0, c_zero(), 0);
    push("bne_skipped", I_BNE, 0, 0, 4'hF, 0, c_fetch(0), 0);
    push("beq_fetch",   I_BEQ, 0, 1, 4'hF, 0, c_fetch(1), 0);
    push("beq_decode",  I_BEQ, 0, 1, 4'hF, 0, c_zero(), 0);
    push("beq_branch",  I_BEQ, 0, 1, 4'hF, 0, c_br(0), 0);
    push("bl_fetch",    I_BL,  0, 1, 4'hF, 0, c_fetch(1), 0);
    push("bl_decode",   I_BL,  0, 1, 4'hF, 0, c_zero(), 0);
`ifdef CTRL_BL_LINK_EN
    push("bl_branch",   I_BL,  0, 1, 4'hF, 0, c_br(1), 0);
`else
    push("bl_branch",   I_BL,  0, 1, 4'hF, 0, c_br(0), 0);
`endif
    push("nv_fetch",    I_NV,  0, 1, 4'hF, 0, c_fetch(1), 0);
    push("nv_decode",   I_NV,  0, 1, 4'hF, 0, c_zero(), 0);
    push("und_fetch",   I_UND, 0, 1, 4'hF, 0, c_fetch(1), 0);
    push("und_decode",  I_UND, 0, 1, 4'hF, 0, c_und(), 0);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      @(negedge clk);
      reset = e.rst; Instr = e.ins; mem_ready = e.rdy; ALUFlags = e.af;
      #1;
      checks++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL %s: observed %h, expected %h (mask %h)", e.name, obs, e.val, e.mask);
      end
    end
  endtask

  task automatic test_ldr_wait();
    exp_t e;
    push("ldr_fetch",  I_LDR, 0, 1, 4'hF, 0, c_fetch(1), 0);
    push("ldr_decode", I_LDR, 0, 1, 4'hF, 0, c_zero(), 0);
    push("ldr_memadr", I_LDR, 0, 1, 4'hF, 0, c_madr(1), 0);
    for (int k = 0; k < 3; k++)
      push("ldr_memrd_wait", I_LDR, 0, 0, 4'hF, 0, c_mrd(), 1);
    push("ldr_memrd_done", I_LDR, 0, 1, 4'hF, 0, c_mrd(), 1);
    push("ldr_memwb",  I_LDR, 0, 1, 4'hF, 0, c_mwb(), 0);
    push("ldr_refetch", I_LDR, 0, 0, 4'hF, 0, c_fetch(0), 0);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      @(negedge clk);
      reset = e.rst; Instr = e.ins; mem_ready = e.rdy; ALUFlags = e.af;
      #1;
      checks++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL %s: observed %h, expected %h (mask %h)", e.name, obs, e.val, e.mask);
      end
    end
  endtask

  task automatic test_str_timeout();
    exp_t e;
    push("str_fetch",  I_STR, 0, 1, 4'hF, 0, c_fetch(1), 0);
    push("str_decode", I_STR, 0, 1, 4'hF, 0, c_zero(), 0);
    push("str_memadr", I_STR, 0, 0, 4'hF, 0, c_madr(0), 0);
    for (int k = 0; k < 15; k++)
      push("str_memwr_wait", I_STR, 0, 0, 4'hF, 0, c_mwr(), 1);
    push("str_timeout", I_STR, 0, 0, 4'hF, 0, c_err(), 1);
    push("str_refetch", I_STR, 0, 0, 4'hF, 0, c_fetch(0), 0);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      @(negedge clk);
      reset = e.rst; Instr = e.ins; mem_ready = e.rdy; ALUFlags = e.af;
      #1;
      checks++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL %s: observed %h, expected %h (mask %h)", e.name, obs, e.val, e.mask);
      end
    end
  endtask

  task automatic test_reset_memwb();
    exp_t e;
    push("rst_ldr_fetch",  I_LDR, 0, 1, 4'hF, 0, c_fetch(1), 0);
    push("rst_ldr_decode", I_LDR, 0, 1, 4'hF, 0, c_zero(), 0);
    push("rst_ldr_memadr", I_LDR, 0, 1, 4'hF, 0, c_madr(1), 0);
    push("rst_ldr_memrd",  I_LDR, 0, 1, 4'hF, 0, c_mrd(), 1);
    push("rst_in_memwb",   I_LDR, 1, 1, 4'hF, 0, c_zero(), 0);
    push("rst_after_fetch", I_LDR, 0, 0, 4'hF, 0, c_fetch(0), 0);
    push("rst_flags_nv_gone", I_BEQ, 0, 1, 4'hF, 0, c_fetch(1), 0);
    push("rst_beq_decode", I_BEQ, 0, 1, 4'hF, 0, c_zero(), 0);
    push("rst_beq_notaken", I_BEQ, 0, 0, 4'hF, 0, c_fetch(0), 0);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      @(negedge clk);
      reset = e.rst; Instr = e.ins; mem_ready = e.rdy; ALUFlags = e.af;
      #1;
      checks++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL %s: observed %h, expected %h (mask %h)", e.name, obs, e.val, e.mask);
      end
    end
  endtask

  initial begin
    reset = 1'b1; Instr = '0; ALUFlags = '0; mem_ready = 1'b0;
    test_reset();
    test_adds();
    test_cond_branch();
    test_ldr_wait();
    test_str_timeout();
    test_reset_memwb();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multicycle main controller that sequences the ARM datapath over several clocks per instruction: fetch, decode, execute, memory, writeback.
- Drives the datapath control inputs: RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemtoReg, PCSrc, linkSelect, shiftOp, storedCarry.
- Owns the architectural NZCV flag register and the condition-code check.
- Stalls on a memory ready handshake.

Parameters:
- MEM_TIMEOUT, 15, maximum wait cycles in any memory state before the memory error flag `mem_err` pulses and the FSM returns to FETCH.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- Instr  in  32  instruction register contents (valid from DECODE onward)
- ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle
- mem_ready  in  1  memory completes the current access this cycle
- IRWrite  out  1  latch fetched instruction
- PCWrite  out  1  update PC
- AdrSrc  out  1  0 = PC address, 1 = ALUResult address
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- RegSrc  out  2  register-read mux selects
- RegWrite  out  1  register file write enable
- ImmSrc  out  2  extend mode (00 DP imm8, 01 mem imm12, 10 branch imm24)
- ALUSrc  out  1  1 = immediate operand
- ALUControl  out  4  ALU operation
- MemtoReg  out  1  writeback from ReadData
- PCSrc  out  1  PC from Result
- linkSelect  out  1  write PC+4 to R14 (BL)
- shiftOp  out  3  {Instr[4], Instr[6:5]}, passed through to the shifter
- storedCarry  out  1  C bit of the flag register
- undef  out  1  1-cycle pulse on an unsupported op
- mem_err  out  1  1-cycle pulse on memory timeout

Behaviour:
- Reset (synchronous, active-high):
  - State is FETCH; flags = 0000; wait counter = 0.
  - All outputs are 0 while reset is high.
  - Reset mid-instruction aborts the instruction; no register, memory or PC write occurs in that cycle.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- FETCH:
  - MemRead=1, AdrSrc=0.
  - While !mem_ready: hold and increment the wait counter.
  - On mem_ready: IRWrite=1 and PCWrite=1 (PC+4), then go to DECODE.
- DECODE:
  - Evaluate cond=Instr[31:28] against the flag register: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL; 1111 is treated as fail.
  - Fail: go to FETCH with no side effects.
  - op=Instr[27:26]:
    - 00 → EXECI if Instr[25], else EXECR
    - 01 → MEMADR
    - 10 → BRANCH
    - 11 → pulse undef, go to FETCH
- EXECR / EXECI:
  - ALUControl=Instr[24:21]; ALUSrc=Instr[25]; ImmSrc=00.
  - Go to ALUWB.
- ALUWB:
  - RegWrite=1 unless cmd is 10xx (TST/TEQ/CMP/CMN).
  - If S=Instr[20], latch ALUFlags into the flag register on this edge.
  - Go to FETCH.
- MEMADR:
  - ALUSrc=1; ImmSrc=01.
  - ALUControl = ADD (0100) if U=Instr[23], else SUB (0010).
  - L=Instr[20]: go to MEMRD; otherwise go to MEMWR.
- MEMRD: AdrSrc=1, MemRead=1; hold until mem_ready, then go to MEMWB.
- MEMWB: MemtoReg=1, RegWrite=1, then go to FETCH.
- MEMWR:
  - AdrSrc=1, MemWrite=1, RegSrc[1]=1.
  - Hold until mem_ready, then go to FETCH.
- BRANCH:
  - RegSrc[0]=1, ImmSrc=10, ALUSrc=1, ALUControl=ADD, PCSrc=1, PCWrite=1.
  - Go to FETCH.
- Wait counter:
  - Clears on any state change.
  - On reaching MEM_TIMEOUT in FETCH, MEMRD or MEMWR: pulse mem_err, deassert requests, go to FETCH.
- Flag timing: flags written in ALUWB are visible to the next instruction's DECODE.
- Flags are only written in ALUWB, so no other state can write them in the same cycle.
- Outputs are Moore from the state plus Instr fields; no output depends on mem_ready, except that IRWrite and PCWrite in FETCH are gated by mem_ready.

Optional Feature:
- Macro: CTRL_BL_LINK_EN.
- Defined: in BRANCH, if Instr[24] (BL), RegWrite=1 and linkSelect=1, writing R14 in the same cycle as the PC update.
- Undefined: linkSelect is tied to 0 and BL executes as a plain B.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum
  - cond-code constants
  - op constants (OP_DP, OP_MEM, OP_BR)
  - ALU op constants (ALU_ADD=0100, ALU_SUB=0010)
  - ImmSrc constants
- One sub-module, cond_check: combinational {cond, flags} → pass.

Test Plan:
- ADDS R1,R2,#5 with R2=0xFFFFFFFB, mem_ready=1 → sequence FETCH, DECODE, EXECI, ALUWB; RegWrite in ALUWB; flags = Z=1, C=1; storedCarry=1 next cycle.
- CMP then BNE with equal operands → CMP issues no RegWrite; BNE's DECODE fails; no PCSrc/PCWrite after FETCH.
- LDR with mem_ready held low 3 cycles in MEMRD → MemRead held 3 extra cycles; MemWB RegWrite exactly once.
- STR with mem_ready never asserted → mem_err pulses after 15 cycles in MEMWR; next state FETCH; no RegWrite.
- Reset asserted in MEMWB → no RegWrite that cycle; next state FETCH; flags 0000; all outputs 0.
- BL with CTRL_BL_LINK_EN defined → in BRANCH, PCWrite=1, RegWrite=1, linkSelect=1. With the macro undefined → linkSelect=0 and RegWrite=0.
